// File: rtl/branch_control_unit.sv
// Branch control unit: owns the PC, decodes the control status code into
// sequential, conditional, register-indirect and memory-indirect flow changes,
// keeps the Z/N condition flags and drives the $31 link write.
module branch_control_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  status,
  input  logic        instr_valid,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr,
  input  logic        alu_zero,
  input  logic [31:0] alu_result,
  input  logic        flag_we,
  input  logic [31:0] rs_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic        stall,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        illegal
);

  // Handshake: mem_req rises the cycle after a memory-indirect op is accepted
  // and stays high up to and including the cycle mem_ack=1 is seen; the ack
  // cycle completes the access. Ack outside that window is ignored.

  localparam logic [2:0] ST_SEQ  = 3'b000;
  localparam logic [2:0] ST_BMN  = 3'b001;
  localparam logic [2:0] ST_BRZ  = 3'b010;
  localparam logic [2:0] ST_BZ   = 3'b011;
  localparam logic [2:0] ST_JMOR = 3'b100;
  localparam logic [2:0] ST_JALM = 3'b101;
  localparam logic [2:0] ST_RSVD = 3'b110;
  localparam logic [2:0] ST_BEQ  = 3'b111;

  typedef enum logic {S_EXEC, S_WAIT} state_t;

  // Observable state for checkers
  state_t      state;
  logic        z_flag;
  logic        n_flag;
  logic        pend_jalm;
  logic [31:0] pc4_saved;

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        exec_valid;
  logic        go_wait;

  assign pc4        = pc + 32'd4;
  assign br_off     = {{14{imm16[15]}}, imm16, 2'b00};
  assign exec_valid = (state == S_EXEC) && instr_valid;
  assign go_wait    = exec_valid && (((status == ST_BMN) && n_flag) || (status == ST_JALM));
  assign stall      = (state == S_WAIT) || go_wait;
  assign illegal    = exec_valid && (status == ST_RSVD);
  assign next_pc    = target & 32'hFFFF_FFFC;

  // Select the EXEC-state target for the current status code (flags pre-update)
  always_comb begin
    target = pc4;
    case (status)
      ST_BEQ:  target = alu_zero ? (pc4 + br_off) : pc4;
      ST_BRZ:  target = z_flag ? rs_data : pc4;
      ST_BZ:   target = z_flag ? {pc4[31:28], jaddr, 2'b00} : pc4;
      ST_JMOR: target = rs_data;
      default: target = pc4;
    endcase
  end

  // Link write: jmor in its own cycle, jalm in the ack cycle of its access
  always_comb begin
    link_we   = 1'b0;
    link_data = pc4;
    if (reset_n) begin
      if (exec_valid && (status == ST_JMOR)) begin
        link_we   = 1'b1;
        link_data = pc4;
      end else if ((state == S_WAIT) && mem_ack && pend_jalm) begin
        link_we   = 1'b1;
        link_data = pc4_saved;
      end
    end
  end

  // Control FSM, PC, flags and memory-indirect request registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_EXEC;
      pc        <= RESET_PC;
      z_flag    <= 1'b0;
      n_flag    <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'h0;
      pend_jalm <= 1'b0;
      pc4_saved <= 32'h0;
    end else begin
      case (state)
        S_EXEC: begin
          if (flag_we) begin
            z_flag <= (alu_result == 32'h0);
            n_flag <= alu_result[31];
          end
          if (go_wait) begin
            state     <= S_WAIT;
            mem_req   <= 1'b1;
            mem_addr  <= rs_data;
            pc4_saved <= pc4;
            pend_jalm <= (status == ST_JALM);
          end else if (instr_valid) begin
            pc <= next_pc;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            state   <= S_EXEC;
            mem_req <= 1'b0;
            pc      <= mem_rdata & 32'hFFFF_FFFC;
          end
        end
        default: state <= S_EXEC;
      endcase
    end
  end

endmodule

// File: doc/branch_control_unit.md
BRANCH_CONTROL_UNIT -- requirements
Module: branch_control_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: reset_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have port: status  in  3  {status2,status1,status0} from main control decoder.
REQ-005 SHALL have port: instr_valid  in  1  current instruction valid.
REQ-006 SHALL have port: imm16  in  16  branch offset, sign-extended, word units.
REQ-007 SHALL have port: jaddr  in  26  pseudo-direct jump field.
REQ-008 SHALL have port: alu_zero  in  1  ALU zero, current cycle (beq compare).
REQ-009 SHALL have port: alu_result  in  32  ALU result for flag capture.
REQ-010 SHALL have port: flag_we  in  1  capture Z/N flags this cycle.
REQ-011 SHALL have port: rs_data  in  32  register rs value.
REQ-012 SHALL have port: mem_req  out  1  memory-indirect read request, registered.
REQ-013 SHALL have port: mem_addr  out  32  indirect read address, registered.
REQ-014 SHALL have port: mem_ack  in  1  read data valid.
REQ-015 SHALL have port: mem_rdata  in  32  indirect target word.
REQ-016 SHALL have port: pc  out  32  current PC, registered.
REQ-017 SHALL have port: stall  out  1  upstream must hold current instruction.
REQ-018 SHALL have port: link_we  out  1  one-cycle write of $31.
REQ-019 SHALL have port: link_data  out  32  return address for $31.
REQ-020 SHALL have port: illegal  out  1  reserved status code seen, combinational.

Function
REQ-021 SHALL decode status: 000 seq, 111 beq, 001 bmn, 010 brz, 011 bz, 100 jmor, 101 jalm, 110 reserved.
REQ-022 SHALL compute pc4 = pc+4 modulo 2^32; wrap 0xFFFF_FFFC -> 0x0000_0000.
REQ-023 SHALL, for seq/not-taken, load pc <= pc4.
REQ-024 SHALL, for beq, load pc <= pc4 + (sext(imm16)<<2) when alu_zero=1, else pc4.
REQ-025 SHALL, for brz, load pc <= rs_data when Z=1, else pc4.
REQ-026 SHALL, for bz, load pc <= {pc4[31:28], jaddr, 2'b00} when Z=1, else pc4.
REQ-027 SHALL, for jmor, load pc <= rs_data and pulse link_we with link_data = pc4 in the same cycle.
REQ-028 SHALL force bits [1:0] of every computed target to 0.
REQ-029 SHALL implement FSM states EXEC and WAIT; EXEC -> WAIT on bmn with N=1 or jalm; WAIT -> EXEC in cycle mem_ack=1.
REQ-030 SHALL, on EXEC -> WAIT, latch mem_addr <= rs_data and pc4, hold pc, and assert mem_req from the next cycle until the ack cycle inclusive.
REQ-031 SHALL, in the ack cycle, load pc <= {mem_rdata[31:2],2'b00}; jalm additionally pulses link_we with link_data = latched pc4.
REQ-032 SHALL drive stall = (state==WAIT) | (EXEC and transition to WAIT); pc holds whenever stall=1.
REQ-033 SHALL advance pc only when instr_valid=1 in EXEC; otherwise pc holds and no side effects.
REQ-034 SHALL hold Z/N flags; on flag_we in EXEC: Z <= (alu_result==0), N <= alu_result[31]; branches use pre-update flags.
REQ-035 SHALL ignore flag_we, instr_valid, status in WAIT, and mem_ack in EXEC.
REQ-036 SHALL, for 110, assert illegal in that cycle and load pc <= pc4.
REQ-037 SHALL keep link_we 0 except as in REQ-027/031; link_data unspecified when link_we=0.

Reset
REQ-038 SHALL, on rising clk with reset_n=0, set pc=RESET_PC, state=EXEC, Z=0, N=0, mem_req=0, mem_addr=0, link_we=0.
REQ-039 SHALL, on reset during WAIT, abandon the access; mem_req=0 after that edge, later mem_ack ignored.
REQ-040 SHALL give reset priority over all other inputs.

Verification
REQ-041 SHALL test: reset, then 3 cycles status=000 valid -> pc 0x0,0x4,0x8,0xC.
REQ-042 SHALL test: pc=0x100, beq, imm16=0xFFFF, alu_zero=1 -> pc=0x100; alu_zero=0 -> pc=0x104.
REQ-043 SHALL test: flag_we, alu_result=0x8000_0000 -> N=1; bmn, rs_data=0x2000; ack 3 cycles later with 0x3000 -> mem_addr=0x2000, stall high 4 cycles, pc=0x3000.
REQ-044 SHALL test: pc=0x40, jalm, ack rdata=0x500 -> link_we pulse with link_data=0x44 in ack cycle, pc=0x500.
REQ-045 SHALL test: pc=0xFFFF_FFFC seq -> pc=0x0; status=110 -> illegal=1, pc+4.
REQ-046 SHALL test: reset_n=0 during WAIT -> pc=RESET_PC, mem_req=0; later mem_ack=1 -> no pc change.
